// File: rtl/adc_stream_packer.sv
// Joins NUM_CH ADC streams, reduces each 16-bit sample to 8 bits and gearboxes the merged
// word to OUT_W with capture framing. Define ADC_PACK_SAT_EN for saturating reduction.
module adc_stream_packer #(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned SPB    = 4,
  parameter int unsigned OUT_W  = 128
) (
  input  logic                     ps_clk,
  input  logic                     ps_rst,
  input  logic [NUM_CH*SPB*16-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [OUT_W-1:0]         m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [31:0]              cap_beats,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              beat_cnt,
  output logic [31:0]              stall_cnt
);

  localparam int unsigned M     = NUM_CH * SPB * 8;
  localparam int unsigned BUF_W = M + OUT_W;
  localparam int unsigned FW    = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [BUF_W-1:0]    pbuf_q, pbuf_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
  logic [31:0]         cap_q, cap_d;
  logic [31:0]         beat_q, beat_d;
  logic [31:0]         stall_q, stall_d;

  logic [M-1:0]        merged;
  logic [BUF_W-1:0]    merged_ext;
  logic [BUF_W-1:0]    shifted;
  logic [FW-1:0]       fill_after;
  logic [31:0]         fill_w;
  logic                all_valid;
  logic                pop;
  logic                room;
  logic                join_ok;

  function automatic logic [7:0] reduce(input logic [15:0] x);
    logic signed [16:0] r;
    r = ($signed({x[15], x}) + 17'sd128) >>> 8;
`ifdef ADC_PACK_SAT_EN
    if (r > 17'sd127) begin
      return 8'h7f;
    end else if (r < -17'sd128) begin
      return 8'h80;
    end
    return r[7:0];
`else
    return r[7:0];
`endif
  endfunction

  // Sample-major interleave: byte k = s*NUM_CH + c; disabled channels read as zero.
  always_comb begin
    merged = '0;
    for (int s = 0; s < int'(SPB); s++) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (ch_en_q[c]) begin
          merged[(s*NUM_CH + c)*8 +: 8] = reduce(s_tdata[(c*SPB + s)*16 +: 16]);
        end
      end
    end
  end

  assign merged_ext = {{OUT_W{1'b0}}, merged};

  always_comb begin
    fill_w    = 32'(fill_q);
    all_valid = &(s_tvalid | ~ch_en_q);
    m_tvalid  = (state_q == StRun) && (fill_q >= FW'(OUT_W));
    pop       = m_tvalid && m_tready;
    room      = (fill_w + 32'(M) <= 32'(BUF_W)) ||
                (pop && (fill_w - 32'(OUT_W) + 32'(M) <= 32'(BUF_W)));
    join_ok   = (state_q == StRun) && !abort && all_valid && room;
    s_tready  = (state_q == StRun) ? (~ch_en_q | {NUM_CH{join_ok}}) : '1;
    m_tdata   = pbuf_q[OUT_W-1:0];
    m_tlast   = m_tvalid && (beat_q == cap_q - 32'd1);
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    beat_cnt  = beat_q;
    stall_cnt = stall_q;
  end

  // Bits at and above fill are kept zero, so a join can simply OR the new word in.
  always_comb begin
    state_d    = state_q;
    pbuf_d     = pbuf_q;
    fill_d     = fill_q;
    ch_en_d    = ch_en_q;
    cap_d      = cap_q;
    beat_d     = beat_q;
    stall_d    = stall_q;
    shifted    = pop ? (pbuf_q >> OUT_W) : pbuf_q;
    fill_after = pop ? (fill_q - FW'(OUT_W)) : fill_q;

    if (abort) begin
      state_d = StIdle;
      fill_d  = '0;
      pbuf_d  = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StRun;
            fill_d  = '0;
            pbuf_d  = '0;
            beat_d  = '0;
            stall_d = '0;
            ch_en_d = ch_en;
            cap_d   = (cap_beats == 32'd0) ? 32'd1 : cap_beats;
          end
        end
        StRun: begin
          if (pop) begin
            beat_d = beat_q + 32'd1;
          end
          if (pop && m_tlast) begin
            state_d = StDone;
            fill_d  = '0;
            pbuf_d  = '0;
          end else begin
            pbuf_d = shifted;
            fill_d = fill_after;
            if (join_ok) begin
              pbuf_d = shifted | (merged_ext << fill_after);
              fill_d = fill_after + FW'(M);
            end
          end
          if ((|(s_tvalid & ch_en_q)) && !join_ok && (stall_q != 32'hffff_ffff)) begin
            stall_d = stall_q + 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge ps_clk) begin
    if (ps_rst) begin
      state_q <= StIdle;
      pbuf_q  <= '0;
      fill_q  <= '0;
      ch_en_q <= '0;
      cap_q   <= 32'd1;
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pbuf_q  <= pbuf_d;
      fill_q  <= fill_d;
      ch_en_q <= ch_en_d;
      cap_q   <= cap_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_adc_stream_packer.sv
// Randomized scoreboard bench for adc_stream_packer; the reference model tracks the packed
// byte stream as a queue. Honours ADC_PACK_SAT_EN the same way as the design.
module tb_adc_stream_packer;

  localparam int NUM_CH = 6;
  localparam int SPB    = 4;
  localparam int OUT_W  = 128;
  localparam int M      = NUM_CH * SPB * 8;
  localparam int BUF_W  = M + OUT_W;
  localparam int NB     = OUT_W / 8;

  logic                     ps_clk = 1'b0;
  logic                     ps_rst;
  logic [NUM_CH*SPB*16-1:0] s_tdata;
  logic [NUM_CH-1:0]        s_tvalid;
  logic [NUM_CH-1:0]        s_tready;
  logic [OUT_W-1:0]         m_tdata;
  logic                     m_tvalid;
  logic                     m_tready;
  logic                     m_tlast;
  logic                     start;
  logic                     abort;
  logic [NUM_CH-1:0]        ch_en;
  logic [31:0]              cap_beats;
  logic                     busy;
  logic                     done;
  logic [31:0]              beat_cnt;
  logic [31:0]              stall_cnt;

  adc_stream_packer #(
    .NUM_CH(NUM_CH),
    .SPB   (SPB),
    .OUT_W (OUT_W)
  ) dut (
    .ps_clk   (ps_clk),
    .ps_rst   (ps_rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .start    (start),
    .abort    (abort),
    .ch_en    (ch_en),
    .cap_beats(cap_beats),
    .busy     (busy),
    .done     (done),
    .beat_cnt (beat_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 ps_clk = ~ps_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]        q[$];
  bit                running = 1'b0;
  bit                done_m  = 1'b0;
  int unsigned       beats_m = 0;
  int unsigned       stall_m = 0;
  int unsigned       cap_m   = 1;
  logic [NUM_CH-1:0] en_m    = '0;

  // Stimulus knobs
  int                valid_pct  = 100;
  logic [NUM_CH-1:0] vmask      = '0;
  int                ready_mode = 0;
  int                dmode      = 0;
  logic [15:0]       dconst     = '0;
  bit                bchk       = 1'b0;
  logic [7:0]        exp_byte   = '0;
  logic [NUM_CH-1:0] acc        = '0;

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-half-up as floor((x + 128) / 256) on plain integers.
  function automatic logic [7:0] ref_reduce(input logic [15:0] x);
    int v;
    int r;
    v = int'($signed(x)) + 128;
    r = (v >= 0) ? (v / 256) : -((-v + 255) / 256);
`ifdef ADC_PACK_SAT_EN
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`endif
    return 8'(r);
  endfunction

  function automatic logic [15:0] gen(input int c, input int s);
    logic [15:0] edges[4];
    edges = '{16'h7f80, 16'h8000, 16'h7fff, 16'hff7f};
    case (dmode)
      1:       return 16'((c * 16 + s) << 8);
      2:       return dconst;
      default: return ($urandom_range(3) == 0) ? edges[$urandom_range(3)] : 16'($urandom);
    endcase
  endfunction

  task automatic eval_cycle();
    int fillb;
    bit exp_tv, all_v, pop_m, room, join_m;
    logic [NUM_CH-1:0] exp_rdy;
    acc = s_tvalid & s_tready;
    if (ps_rst) begin
      running = 1'b0;
      done_m  = 1'b0;
      q.delete();
      beats_m = 0;
      stall_m = 0;
      return;
    end
    fillb   = q.size() * 8;
    exp_tv  = running && (fillb >= OUT_W);
    all_v   = &(s_tvalid | ~en_m);
    pop_m   = exp_tv && m_tready;
    room    = (fillb + M <= BUF_W) || (pop_m && (fillb - OUT_W + M <= BUF_W));
    join_m  = running && !abort && all_v && room;
    exp_rdy = running ? (~en_m | {NUM_CH{join_m}}) : '1;
    check("s_tready", OUT_W'(s_tready), OUT_W'(exp_rdy));
    check("m_tvalid", OUT_W'(m_tvalid), OUT_W'(exp_tv));
    if (!exp_tv) check("m_tlast_novalid", OUT_W'(m_tlast), '0);
    check("busy", OUT_W'(busy), OUT_W'(running));
    check("done", OUT_W'(done), OUT_W'(done_m));
    check("beat_cnt", OUT_W'(beat_cnt), OUT_W'(beats_m));
    check("stall_cnt", OUT_W'(stall_cnt), OUT_W'(stall_m));
    if (abort) begin
      running = 1'b0;
      done_m  = 1'b0;
      q.delete();
    end else if (running) begin
      if (join_m) begin
        for (int s = 0; s < SPB; s++) begin
          for (int c = 0; c < NUM_CH; c++) begin
            q.push_back(en_m[c] ? ref_reduce(s_tdata[(c*SPB + s)*16 +: 16]) : 8'h00);
          end
        end
      end
      if ((|(s_tvalid & en_m)) && !join_m && (stall_m != 32'hffff_ffff)) stall_m++;
    end else if (start) begin
      running = 1'b1;
      done_m  = 1'b0;
      q.delete();
      beats_m = 0;
      stall_m = 0;
      en_m    = ch_en;
      cap_m   = (cap_beats == 0) ? 1 : cap_beats;
    end
  endtask

  task automatic monitor_cycle();
    logic [OUT_W-1:0] e;
    bit exp_last;
    if (ps_rst || abort || !(m_tvalid && m_tready)) return;
    if (q.size() < NB) begin
      checks++;
      errors++;
      $display("FAIL pop_underflow actual=%0d bytes required>=%0d at %0t", q.size(), NB, $time);
      return;
    end
    for (int i = 0; i < NB; i++) e[i*8 +: 8] = q.pop_front();
    check("m_tdata", m_tdata, e);
    if (bchk) check("m_tdata_const", m_tdata, {NB{exp_byte}});
    exp_last = (beats_m == cap_m - 1);
    check("m_tlast", OUT_W'(m_tlast), OUT_W'(exp_last));
    beats_m++;
    if (exp_last) begin
      running = 1'b0;
      done_m  = 1'b1;
      q.delete();
    end
  endtask

  always begin
    @(negedge ps_clk);
    eval_cycle();
  end

  always begin
    @(negedge ps_clk);
    #2;
    monitor_cycle();
  end

  always begin
    @(posedge ps_clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!s_tvalid[c] || acc[c]) begin
        s_tvalid[c] = vmask[c] && ($urandom_range(99) < valid_pct);
        for (int s = 0; s < SPB; s++) s_tdata[(c*SPB + s)*16 +: 16] = gen(c, s);
      end
    end
    case (ready_mode)
      1:       m_tready = ~m_tready;
      2:       m_tready = 1'($urandom_range(1));
      default: m_tready = 1'b1;
    endcase
  end

  task automatic pulse_start();
    @(posedge ps_clk);
    #1 start = 1'b1;
    @(posedge ps_clk);
    #1 start = 1'b0;
  endtask

  task automatic capture(input logic [NUM_CH-1:0] en, input int cap, input int vpct,
                         input logic [NUM_CH-1:0] vm, input int rmode, input int dm,
                         input logic [15:0] dc, input bit bc, input logic [7:0] eb);
    int n;
    ch_en      = en;
    cap_beats  = cap;
    valid_pct  = vpct;
    vmask      = vm;
    ready_mode = rmode;
    dmode      = dm;
    dconst     = dc;
    bchk       = bc;
    exp_byte   = eb;
    pulse_start();
    n = 0;
    while (!done_m && n < (cap + 1) * 20 + 200) begin
      @(posedge ps_clk);
      n++;
    end
    if (!done_m) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout actual=not_done required=done cap=%0d", cap);
    end
    #1;
    vmask = '0;
    bchk  = 1'b0;
    repeat (4) @(posedge ps_clk);
  endtask

  initial begin
    int n;
    ps_rst    = 1'b1;
    s_tvalid  = '0;
    s_tdata   = '0;
    m_tready  = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    ch_en     = '1;
    cap_beats = 32'd3;
    repeat (3) @(posedge ps_clk);
    #1 ps_rst = 1'b0;
    @(negedge ps_clk);
    #3;
    check("reset_m_tdata", m_tdata, '0);

    // Reduction corner values, all channels enabled
    capture('1, 3, 100, '1, 0, 2, 16'h0080, 1'b1, 8'h01);
    capture('1, 3, 100, '1, 0, 2, 16'hff7f, 1'b1, 8'hff);
`ifdef ADC_PACK_SAT_EN
    capture('1, 3, 100, '1, 0, 2, 16'h7f80, 1'b1, 8'h7f);
`else
    capture('1, 3, 100, '1, 0, 2, 16'h7f80, 1'b1, 8'h80);
`endif
    capture('1, 3, 100, '1, 0, 2, 16'h8000, 1'b1, 8'h80);
    // Interleave pattern, then backpressure and random traffic
    capture('1, 3, 100, '1, 0, 1, '0, 1'b0, '0);
    capture('1, 30, 100, '1, 1, 1, '0, 1'b0, '0);
    capture('1, 30, 100, '1, 1, 0, '0, 1'b0, '0);
    capture('1, 24, 70, '1, 2, 0, '0, 1'b0, '0);
    // Channel 0 disabled and silent; all disabled; zero-length request
    capture(6'b111110, 12, 80, 6'b111110, 2, 0, '0, 1'b0, '0);
    capture('0, 6, 100, '0, 2, 0, '0, 1'b0, '0);
    capture('1, 0, 100, '1, 0, 0, '0, 1'b0, '0);

    // Abort after five beats of a long capture
    ch_en      = '1;
    cap_beats  = 32'd100;
    vmask      = '1;
    valid_pct  = 100;
    ready_mode = 0;
    dmode      = 0;
    pulse_start();
    n = 0;
    while (beats_m < 5 && n < 200) begin
      @(posedge ps_clk);
      n++;
    end
    #1 abort = 1'b1;
    @(posedge ps_clk);
    #1 abort = 1'b0;
    @(negedge ps_clk);
    #3;
    check("abort_m_tvalid", OUT_W'(m_tvalid), '0);
    check("abort_busy", OUT_W'(busy), '0);
    check("abort_beat_cnt", OUT_W'(beat_cnt), OUT_W'(5));
    capture('1, 4, 100, '1, 0, 0, '0, 1'b0, '0);

    // Synchronous reset while output is valid
    ch_en     = '1;
    cap_beats = 32'd50;
    vmask     = '1;
    pulse_start();
    n = 0;
    while (!m_tvalid && n < 50) begin
      @(negedge ps_clk);
      n++;
    end
    check("rst_pre_m_tvalid", OUT_W'(m_tvalid), OUT_W'(1));
    @(posedge ps_clk);
    #1 ps_rst = 1'b1;
    @(posedge ps_clk);
    #1 ps_rst = 1'b0;
    @(negedge ps_clk);
    #3;
    check("rst_m_tvalid", OUT_W'(m_tvalid), '0);
    check("rst_m_tlast", OUT_W'(m_tlast), '0);
    check("rst_m_tdata", m_tdata, '0);
    check("rst_s_tready", OUT_W'(s_tready), OUT_W'({NUM_CH{1'b1}}));
    check("rst_busy_done", OUT_W'({busy, done}), '0);
    check("rst_counters", OUT_W'({beat_cnt, stall_cnt}), '0);
    vmask = '0;
    repeat (4) @(posedge ps_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
